// File: rtl/ieee754_to_fixed.sv
// ieee754_to_fixed: 3-stage IEEE754 single -> signed W-bit fixed point with F_BITS fraction bits, full stall on backpressure.
// Define IEEE754_TO_FIXED_FLAGS_EN to add out_ovf/out_nan, sticky_ovf and clear_flags.
module ieee754_to_fixed #(
  parameter int W = 32,
  parameter int F_BITS = 18
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef IEEE754_TO_FIXED_FLAGS_EN
  ,
  output logic         out_ovf,
  output logic         out_nan,
  output logic         sticky_ovf,
  input  logic         clear_flags
`endif
);
  localparam logic [W+23:0] HALF = (W+24)'(1) << (W-1);
  localparam logic [W+1:0] LIM_N = (W+2)'(1) << (W-1);
  localparam logic [W+1:0] LIM_P = LIM_N - (W+2)'(1);
  logic stall, adv;
  logic v1_q, s1_q, zero1_q, inf1_q, nan1_q;
  logic [23:0] mant1_q;
  logic signed [9:0] sh1_q;
  logic v2_q, s2_q, ovf2_q, rnd2_q;
  logic [W:0] mag2_q;
  logic v3_q;
  logic [W-1:0] data3_q;
  logic [7:0] e;
  logic signed [9:0] sh1_d;
  logic [W+23:0] wide;
  logic [9:0] n;
  logic [23:0] t;
  logic left, ovf2_d, rnd2_d, sat;
  logic [W:0] mag2_d;
  logic [W+1:0] sum;
  logic [W-1:0] data3_d;
  assign stall = v3_q & ~out_ready;
  assign adv = ~stall;
  assign in_ready = ~resetn & adv;
  assign out_valid = v3_q;
  assign out_data = data3_q;
  assign e = in_data[30:23];
  assign sh1_d = $signed({2'b00, e}) - 10'sd150 + 10'(F_BITS);
  // t keeps one extra low bit so t[0] is the round bit and t[23:1] the right-shifted magnitude
  always_comb begin
    left = ~sh1_q[9];
    wide = {{W{1'b0}}, mant1_q} << sh1_q;
    n = -sh1_q;
    t = mant1_q >> (n - 10'd1);
    ovf2_d = inf1_q | (~zero1_q & ~nan1_q & (left ? (sh1_q >= 10'(W)) | (wide > HALF)
                                                  : ({{(W+1){1'b0}}, t[23:1]} > HALF)));
    mag2_d = (zero1_q | nan1_q) ? '0 : (left ? wide[W:0] : (W+1)'(t[23:1]));
    rnd2_d = ~zero1_q & ~nan1_q & ~left & (n <= 10'd24) & t[0];
  end
  always_comb begin
    sum = {1'b0, mag2_q} + (W+2)'(rnd2_q);
    sat = ovf2_q | (sum > (s2_q ? LIM_N : LIM_P));
    data3_d = sat ? (s2_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                  : (s2_q ? -sum[W-1:0] : sum[W-1:0]);
  end
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      {v1_q, s1_q, zero1_q, inf1_q, nan1_q, mant1_q, sh1_q} <= '0;
      {v2_q, s2_q, ovf2_q, rnd2_q, mag2_q} <= '0;
      {v3_q, data3_q} <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      s1_q <= in_data[31];
      mant1_q <= {1'b1, in_data[22:0]};
      sh1_q <= sh1_d;
      zero1_q <= e == 8'd0;
      inf1_q <= (&e) & ~(|in_data[22:0]);
      nan1_q <= (&e) & (|in_data[22:0]);
      v2_q <= v1_q;
      s2_q <= s1_q;
      mag2_q <= mag2_d;
      ovf2_q <= ovf2_d;
      rnd2_q <= rnd2_d;
      v3_q <= v2_q;
      data3_q <= data3_d;
    end
  end
`ifdef IEEE754_TO_FIXED_FLAGS_EN
  logic nan2_q, ovf3_q, nan3_q, sticky_q;
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      {nan2_q, ovf3_q, nan3_q, sticky_q} <= '0;
    end else begin
      if (adv) begin
        nan2_q <= nan1_q;
        ovf3_q <= sat;
        nan3_q <= nan2_q;
      end
      sticky_q <= clear_flags ? 1'b0 : sticky_q | (v3_q & out_ready & ovf3_q);
    end
  end
  assign out_ovf = ovf3_q;
  assign out_nan = nan3_q;
  assign sticky_ovf = sticky_q;
`endif
endmodule

// File: tb/tb_ieee754_to_fixed.sv
// tb_ieee754_to_fixed: directed, backpressure, reset and random checks against a real-arithmetic model.
`timescale 1ns/1ps
module tb_ieee754_to_fixed;
  logic clock = 0, resetn = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
`ifdef IEEE754_TO_FIXED_FLAGS_EN
  logic out_ovf, out_nan, sticky_ovf;
  logic clear_flags = 0;
`endif
  int n_cmp = 0, n_bad = 0, adv_cnt = 0, stall_cnt = 0;
  bit rand_bp = 0;
  typedef struct {logic [31:0] d; logic ovf; logic nan; int stamp;} exp_t;
  exp_t q[$];
  localparam logic [31:0] VIN [16] = '{32'h3F800000, 32'hC0200000, 32'h00000000, 32'h80000000,
    32'h36000000, 32'hB6000000, 32'h35800000, 32'h46000000, 32'hC6000000, 32'h7F800000,
    32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h4F000000, 32'h3FC00000, 32'h36400000};
  localparam logic [31:0] VEXP [16] = '{32'h00040000, 32'hFFF60000, 32'h00000000, 32'h00000000,
    32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
    32'h80000000, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h00060000, 32'h00000001};

  ieee754_to_fixed #(.W(32), .F_BITS(18)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef IEEE754_TO_FIXED_FLAGS_EN
    , .out_ovf(out_ovf), .out_nan(out_nan), .sticky_ovf(sticky_ovf), .clear_flags(clear_flags)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [31:0] f, output logic ovf, output logic nan);
    int e;
    real m;
    longint v;
    e = int'(f[30:23]);
    ovf = 0;
    nan = 0;
    if (e == 255) begin
      nan = (f[22:0] != 0);
      ovf = !nan;
      return nan ? 32'h0 : (f[31] ? 32'h80000000 : 32'h7FFFFFFF);
    end
    if (e == 0) return 32'h0;
    m = $floor((8388608.0 + real'(f[22:0])) * (2.0 ** (e - 132)) + 0.5);
    if (m > (f[31] ? 2147483648.0 : 2147483647.0)) begin
      ovf = 1;
      return f[31] ? 32'h80000000 : 32'h7FFFFFFF;
    end
    v = longint'(m);
    return f[31] ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] to_single(input real x);
    logic [63:0] d;
    int e;
    d = $realtobits(x);
    e = int'(d[62:52]) - 1023 + 127;
    if (x == 0.0 || e <= 0) return {d[63], 31'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string got, input string want);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s expected %s", nm, got, want);
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int k;
    in_valid = 1;
    in_data = w;
    k = 0;
    @(negedge clock);
    while (!in_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (!in_ready) fail("send_timeout", "in_ready=0", "in_ready=1");
    @(posedge clock);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin : compare
    exp_t x;
    logic o, nn;
    logic [31:0] dd, prev_data;
    bit prev_stall;
    prev_stall = 0;
    prev_data = 0;
    forever begin
      @(negedge clock);
      if (resetn) begin
        q.delete();
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
        end
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", in_ready, 0);
          stall_cnt++;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) fail("unexpected_out", $sformatf("%h", out_data), "no output");
          else begin
            x = q.pop_front();
            chk("data", out_data, x.d);
            chk("latency", adv_cnt - x.stamp, 3);
`ifdef IEEE754_TO_FIXED_FLAGS_EN
            chk("ovf", out_ovf, x.ovf);
            chk("nan", out_nan, x.nan);
`endif
          end
        end
        if (in_valid && in_ready) begin
          dd = model(in_data, o, nn);
          q.push_back('{d: dd, ovf: o, nan: nn, stamp: adv_cnt});
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        if (!prev_stall) adv_cnt++;
      end
    end
  end

  initial begin : bp_rand
    forever begin
      @(posedge clock);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    logic o, nn;
    real x;
    int s0;
    #1 resetn = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    sync();
    resetn = 0;
    #1 chk("ready_after_release", in_ready, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("model_%h", VIN[i]), model(VIN[i], o, nn), VEXP[i]);
    void'(model(32'h46000000, o, nn));
    chk("model_ovf_pos", o, 1);
    void'(model(32'hC6000000, o, nn));
    chk("model_ovf_negmin", o, 0);
    void'(model(32'h7FC00000, o, nn));
    chk("model_nan", nn, 1);
    sync();
    for (int i = 0; i < 16; i++) send(VIN[i]);
    drain();
`ifdef IEEE754_TO_FIXED_FLAGS_EN
    sync();
    chk("sticky_set", sticky_ovf, 1);
    clear_flags = 1;
    sync();
    clear_flags = 0;
    chk("sticky_clear", sticky_ovf, 0);
`endif
    sync();
    s0 = stall_cnt;
    fork
      begin
        repeat (3) @(posedge clock);
        #1 out_ready = 0;
        repeat (4) @(posedge clock);
        #1 out_ready = 1;
      end
    join_none
    for (int i = 0; i < 8; i++) send(32'h40000000 + 32'(i) * 32'h00100000);
    drain();
    chk("bp_stall_cycles", stall_cnt - s0, 4);
    sync();
    for (int i = 0; i < 3; i++) send(32'h41000000 + 32'(i) * 32'h00200000);
    resetn = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 0;
    send(32'hC1100000);
    send(32'h3E800000);
    drain();
    repeat (6) @(negedge clock);
    sync();
    rand_bp = 1;
    for (int i = 0; i < 10000; i++) begin
      x = 0.0;
      repeat (12) x += real'($urandom_range(0, 65535)) / 65536.0;
      if ($urandom_range(0, 7) == 0) sync();
      send(to_single((x - 6.0) * 100.0));
    end
    rand_bp = 0;
    out_ready = 1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
